// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch buffer: states, line geometry, bus tag.
package fetch_pkg;

  // Memory-space code from Sysbus.defs.
  localparam logic [3:0]  SYSBUS_MEMORY = 4'b0001;
  localparam logic [12:0] FETCH_TAG     = {1'b1, SYSBUS_MEMORY, 8'b0};

  // Geometry for the default configuration.
  localparam int unsigned DEF_BUS_DATA_WIDTH = 64;
  localparam int unsigned DEF_INSTR_WIDTH    = 32;
  localparam int unsigned DEF_BURST_BEATS    = 8;
  localparam int unsigned IPB        = DEF_BUS_DATA_WIDTH / DEF_INSTR_WIDTH;
  localparam int unsigned IPL        = DEF_BURST_BEATS * IPB;
  localparam int unsigned LINE_BYTES = DEF_BURST_BEATS * DEF_BUS_DATA_WIDTH / 8;

  // Fetch FSM encoding.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_WAIT_SPACE = 2'd0;
  localparam fetch_state_t ST_REQ        = 2'd1;
  localparam fetch_state_t ST_RESP       = 2'd2;
  localparam fetch_state_t ST_DRAIN      = 2'd3;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// System-bus request/response and decode-side instruction handshake.
interface instr_fetch_buffer_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned INSTR_WIDTH    = 32
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      instr_valid;
  logic [INSTR_WIDTH-1:0]    instr;
  logic [63:0]               instr_pc;
  logic                      instr_ready;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output instr_valid, instr, instr_pc,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag, instr_ready
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  instr_valid, instr, instr_pc,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction FIFO: up to NWR compacted writes and one pop per cycle, show-ahead read, flush.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned NWR   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NWR-1:0]            wr_valid,
  input  logic [NWR-1:0][WIDTH-1:0] wr_data,
  input  logic                      pop,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]    free
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic [PW-1:0]    wr_total;
  logic [AW-1:0]    wr_idx [NWR];
  logic             do_pop;

  // Pack valid lanes onto consecutive slots starting at the write pointer.
  always_comb begin
    wr_total = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_idx[k] = AW'(wr_ptr + wr_total);
      wr_total  = wr_total + PW'(wr_valid[k]);
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign rd_valid = (count != '0);
  assign free     = PW'(DEPTH) - count;
  assign do_pop   = pop && rd_valid;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over concurrent push and pop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_total;
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_valid[k]) mem[wr_idx[k]] <= wr_data[k];
      end
    end
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// Line-burst instruction fetcher feeding an in-order instruction FIFO with redirect flush.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BURST_BEATS    = 8,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          entry,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  instr_fetch_buffer_if.master fb
);
  localparam int unsigned N_LANES     = BUS_DATA_WIDTH / INSTR_WIDTH;
  localparam int unsigned LINE_INSTRS = BURST_BEATS * N_LANES;
  localparam int unsigned LINE_SZ     = BURST_BEATS * BUS_DATA_WIDTH / 8;
  localparam int unsigned BEAT_BYTES  = BUS_DATA_WIDTH / 8;
  localparam int unsigned INSTR_BYTES = INSTR_WIDTH / 8;
  localparam int unsigned BEAT_W      = $clog2(BURST_BEATS) + 1;
  localparam int unsigned FREE_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W       = INSTR_WIDTH + 64;
  localparam logic [63:0] LINE_MASK   = ~(64'(LINE_SZ) - 64'd1);
  localparam logic [63:0] INSTR_MASK  = ~(64'(INSTR_BYTES) - 64'd1);

  fetch_state_t state, state_n;
  logic [63:0]  fetch_pc, fetch_pc_n;
  logic [63:0]  line_base, line_base_n;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_n;
  logic         drain_pend, drain_pend_n;
  logic         keep_beat;
  logic         beat_acc;
  logic         last_beat;

  logic [N_LANES-1:0][63:0]      lane_pc;
  logic [N_LANES-1:0]            wr_valid;
  logic [N_LANES-1:0][ENT_W-1:0] wr_data;
  logic                          fifo_valid;
  logic [ENT_W-1:0]              fifo_data;
  logic [FREE_W-1:0]             fifo_free;
  logic                          unused_ok;

  assign beat_acc  = reset && ((state == ST_RESP) || (state == ST_DRAIN)) && fb.bus_respcyc;
  assign last_beat = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
  assign unused_ok = ^fb.bus_resptag;

  // FSM state and fetch bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_REQ;
      fetch_pc   <= entry;
      line_base  <= entry & LINE_MASK;
      beat_cnt   <= '0;
      drain_pend <= 1'b0;
    end else begin
      state      <= state_n;
      fetch_pc   <= fetch_pc_n;
      line_base  <= line_base_n;
      beat_cnt   <= beat_cnt_n;
      drain_pend <= drain_pend_n;
    end
  end

  // Next-state logic; a redirect always retargets fetch_pc and never aborts a bus transaction.
  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    line_base_n  = line_base;
    beat_cnt_n   = beat_cnt;
    drain_pend_n = drain_pend;
    keep_beat    = 1'b0;
    case (state)
      ST_WAIT_SPACE: begin
        if (!redirect_valid && (fifo_free >= FREE_W'(LINE_INSTRS))) begin
          state_n     = ST_REQ;
          line_base_n = fetch_pc & LINE_MASK;
        end
      end
      ST_REQ: begin
        if (fb.bus_reqack) begin
          state_n      = (redirect_valid || drain_pend) ? ST_DRAIN : ST_RESP;
          beat_cnt_n   = '0;
          drain_pend_n = 1'b0;
        end else if (redirect_valid) begin
          drain_pend_n = 1'b1;
        end
      end
      ST_RESP: begin
        if (beat_acc) begin
          keep_beat = !redirect_valid;
          if (last_beat) begin
            state_n    = ST_WAIT_SPACE;
            fetch_pc_n = line_base + 64'(LINE_SZ);
          end else begin
            beat_cnt_n = beat_cnt + BEAT_W'(1);
            if (redirect_valid) state_n = ST_DRAIN;
          end
        end else if (redirect_valid) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_acc) begin
          if (last_beat) state_n = ST_WAIT_SPACE;
          else           beat_cnt_n = beat_cnt + BEAT_W'(1);
        end
      end
      default: state_n = ST_REQ;
    endcase
    if (redirect_valid) fetch_pc_n = redirect_pc & INSTR_MASK;
  end

  // Split the beat into lanes; lanes below fetch_pc belong to skipped instructions.
  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      lane_pc[k]  = line_base + 64'(beat_cnt) * 64'(BEAT_BYTES) + 64'(k) * 64'(INSTR_BYTES);
      wr_valid[k] = keep_beat && (lane_pc[k] >= fetch_pc);
      wr_data[k]  = {lane_pc[k], fb.bus_resp[k*INSTR_WIDTH +: INSTR_WIDTH]};
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .NWR   (N_LANES)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .pop      (reset && fb.instr_ready),
    .rd_valid (fifo_valid),
    .rd_data  (fifo_data),
    .free     (fifo_free)
  );

  assign fb.bus_reqcyc  = reset && (state == ST_REQ);
  assign fb.bus_req     = reset ? BUS_DATA_WIDTH'(line_base) : '0;
  assign fb.bus_reqtag  = reset ? BUS_TAG_WIDTH'(FETCH_TAG) : '0;
  assign fb.bus_respack = beat_acc;
  assign fb.instr_valid = reset && fifo_valid;
  assign fb.instr       = reset ? fifo_data[INSTR_WIDTH-1:0] : '0;
  assign fb.instr_pc    = reset ? fifo_data[ENT_W-1:INSTR_WIDTH] : '0;
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer: line fetch, unaligned entry, backpressure, redirects.
module tb_instr_fetch_buffer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] pop_pc_q  [$];
  logic [31:0] pop_ins_q [$];

  instr_fetch_buffer_if #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .INSTR_WIDTH    (32)
  ) fb_if ();

  instr_fetch_buffer #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .BURST_BEATS    (8),
    .INSTR_WIDTH    (32),
    .FIFO_DEPTH     (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fb             (fb_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  // Record every pop that actually happens at the next rising edge.
  always @(negedge clk) begin
    if (reset && fb_if.instr_valid && fb_if.instr_ready && !redirect_valid) begin
      pop_pc_q.push_back(fb_if.instr_pc);
      pop_ins_q.push_back(fb_if.instr);
    end
  end

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] base, input int b);
    logic [63:0] d;
    logic [63:0] a;
    d = '0;
    for (int k = 0; k < int'(IPB); k++) begin
      a = base + 64'(b * 8) + 64'(k * 4);
      d[k*32 +: 32] = ins_of(a);
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset                = 1'b0;
    entry                = e;
    redirect_valid       = 1'b0;
    redirect_pc          = '0;
    fb_if.bus_reqack     = 1'b0;
    fb_if.bus_respcyc    = 1'b0;
    fb_if.bus_resp       = '0;
    fb_if.bus_resptag    = '0;
    fb_if.instr_ready    = 1'b0;
    tick();
    expect_eq("rst_reqcyc", 64'(fb_if.bus_reqcyc), 64'd0);
    expect_eq("rst_req", 64'(fb_if.bus_req), 64'd0);
    expect_eq("rst_ivalid", 64'(fb_if.instr_valid), 64'd0);
    tick();
    pop_pc_q.delete();
    pop_ins_q.delete();
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 64 && !fb_if.bus_reqcyc; i++) tick();
    expect_eq({tag, "_reqcyc"}, 64'(fb_if.bus_reqcyc), 64'd1);
  endtask

  task automatic do_ack(input int dly);
    tick_n(dly);
    fb_if.bus_reqack = 1'b1;
    tick();
    fb_if.bus_reqack = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int from, input int to);
    for (int b = from; b <= to; b++) begin
      fb_if.bus_respcyc = 1'b1;
      fb_if.bus_resp    = beat_data(base, b);
      tick();
    end
    fb_if.bus_respcyc = 1'b0;
  endtask

  task automatic check_pops(input string tag, input logic [63:0] first_pc, input int n);
    logic [63:0] pc;
    expect_eq({tag, "_count"}, 64'(pop_pc_q.size()), 64'(n));
    for (int i = 0; i < n && i < pop_pc_q.size(); i++) begin
      pc = first_pc + 64'(i * 4);
      expect_eq($sformatf("%s_pc%0d", tag, i), pop_pc_q[i], pc);
      expect_eq($sformatf("%s_ins%0d", tag, i), 64'(pop_ins_q[i]), 64'(ins_of(pc)));
    end
  endtask

  initial begin
    // Aligned entry, ack after 3 cycles, consumer always ready.
    do_reset(64'h1000);
    fb_if.instr_ready = 1'b1;
    expect_eq("t1_reqcyc_first", 64'(fb_if.bus_reqcyc), 64'd1);
    expect_eq("t1_req", 64'(fb_if.bus_req), 64'h1000);
    expect_eq("t1_tag", 64'(fb_if.bus_reqtag), 64'h1100);
    expect_eq("t1_respack_idle", 64'(fb_if.bus_respack), 64'd0);
    tick_n(3);
    expect_eq("t1_reqcyc_held", 64'(fb_if.bus_reqcyc), 64'd1);
    do_ack(0);
    expect_eq("t1_reqcyc_drop", 64'(fb_if.bus_reqcyc), 64'd0);
    expect_eq("t1_ivalid_pre", 64'(fb_if.instr_valid), 64'd0);
    send_beats(64'h1000, 0, 0);
    expect_eq("t1_ivalid_lat", 64'(fb_if.instr_valid), 64'd1);
    expect_eq("t1_ipc_lat", fb_if.instr_pc, 64'h1000);
    send_beats(64'h1000, 1, 7);
    wait_req("t1_next");
    expect_eq("t1_next_req", 64'(fb_if.bus_req), 64'h1000 + 64'(LINE_BYTES));
    tick_n(20);
    check_pops("t1", 64'h1000, int'(IPL));

    // Unaligned entry: first five lanes of the line are skipped.
    do_reset(64'h1014);
    fb_if.instr_ready = 1'b1;
    expect_eq("t2_req", 64'(fb_if.bus_req), 64'h1000);
    do_ack(0);
    send_beats(64'h1000, 0, 7);
    tick_n(20);
    check_pops("t2", 64'h1014, 11);

    // Consumer stalled: two lines fill the FIFO, third waits for 16 pops.
    do_reset(64'h1000);
    do_ack(0);
    send_beats(64'h1000, 0, 7);
    wait_req("t3_l2");
    expect_eq("t3_l2_req", 64'(fb_if.bus_req), 64'h1040);
    do_ack(0);
    send_beats(64'h1040, 0, 7);
    tick_n(10);
    expect_eq("t3_full_reqcyc", 64'(fb_if.bus_reqcyc), 64'd0);
    expect_eq("t3_full_head", fb_if.instr_pc, 64'h1000);
    fb_if.instr_ready = 1'b1;
    tick_n(15);
    fb_if.instr_ready = 1'b0;
    tick_n(3);
    expect_eq("t3_15pop_reqcyc", 64'(fb_if.bus_reqcyc), 64'd0);
    fb_if.instr_ready = 1'b1;
    tick();
    fb_if.instr_ready = 1'b0;
    expect_eq("t3_16pop_reqcyc_now", 64'(fb_if.bus_reqcyc), 64'd0);
    tick();
    expect_eq("t3_l3_reqcyc", 64'(fb_if.bus_reqcyc), 64'd1);
    expect_eq("t3_l3_req", 64'(fb_if.bus_req), 64'h1080);
    expect_eq("t3_head16", fb_if.instr_pc, 64'h1040);
    check_pops("t3", 64'h1000, 16);

    // Redirect mid-burst after beat 3.
    do_reset(64'h1000);
    do_ack(0);
    send_beats(64'h1000, 0, 3);
    expect_eq("t4_ivalid_before", 64'(fb_if.instr_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2008;
    tick();
    redirect_valid = 1'b0;
    expect_eq("t4_ivalid_flushed", 64'(fb_if.instr_valid), 64'd0);
    for (int b = 4; b < 8; b++) begin
      fb_if.bus_respcyc = 1'b1;
      fb_if.bus_resp    = beat_data(64'h1000, b);
      #1;
      expect_eq($sformatf("t4_drain_ack%0d", b), 64'(fb_if.bus_respack), 64'd1);
      tick();
      expect_eq($sformatf("t4_drain_iv%0d", b), 64'(fb_if.instr_valid), 64'd0);
    end
    fb_if.bus_respcyc = 1'b0;
    fb_if.instr_ready = 1'b1;
    wait_req("t4_new");
    expect_eq("t4_new_req", 64'(fb_if.bus_req), 64'h2000);
    do_ack(0);
    send_beats(64'h2000, 0, 7);
    tick_n(20);
    check_pops("t4", 64'h2008, 14);

    // Redirect while the request is pending; ack arrives 5 cycles later.
    do_reset(64'h1000);
    fb_if.instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3010;
    tick();
    redirect_valid = 1'b0;
    expect_eq("t5_reqcyc_held", 64'(fb_if.bus_reqcyc), 64'd1);
    expect_eq("t5_req_held", 64'(fb_if.bus_req), 64'h1000);
    tick_n(4);
    expect_eq("t5_reqcyc_held5", 64'(fb_if.bus_reqcyc), 64'd1);
    do_ack(0);
    send_beats(64'h1000, 0, 7);
    expect_eq("t5_drained_ivalid", 64'(fb_if.instr_valid), 64'd0);
    expect_eq("t5_drained_pops", 64'(pop_pc_q.size()), 64'd0);
    wait_req("t5_new");
    expect_eq("t5_new_req", 64'(fb_if.bus_req), 64'h3000);
    do_ack(0);
    send_beats(64'h3000, 0, 7);
    tick_n(20);
    check_pops("t5", 64'h3010, 12);

    // Redirect together with the final beat and a pop.
    do_reset(64'h1000);
    fb_if.instr_ready = 1'b1;
    do_ack(0);
    send_beats(64'h1000, 0, 6);
    fb_if.bus_respcyc = 1'b1;
    fb_if.bus_resp    = beat_data(64'h1000, 7);
    redirect_valid    = 1'b1;
    redirect_pc       = 64'h4000;
    tick();
    fb_if.bus_respcyc = 1'b0;
    redirect_valid    = 1'b0;
    expect_eq("t6_ivalid_flushed", 64'(fb_if.instr_valid), 64'd0);
    wait_req("t6_new");
    expect_eq("t6_new_req", 64'(fb_if.bus_req), 64'h4000);
    expect_eq("t6_ivalid_after", 64'(fb_if.instr_valid), 64'd0);
    check_pops("t6", 64'h1000, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Parametrised instruction fetch unit between the system bus and the decode stage. Fetches whole cache lines as bus bursts into an instruction FIFO and splits each beat into instructions. Delivers instructions in order with their PCs over a valid/ready handshake. Supports a one-cycle redirect that flushes buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- BUS_DATA_WIDTH, 64, bus beat width in bits.
- BUS_TAG_WIDTH, 13, bus tag width.
- BURST_BEATS, 8, beats per line fetch; LINE_BYTES = BURST_BEATS*BUS_DATA_WIDTH/8.
- INSTR_WIDTH, 32, instruction width; BUS_DATA_WIDTH must be a multiple of it; IPB = BUS_DATA_WIDTH/INSTR_WIDTH.
- FIFO_DEPTH, 32, instruction entries; power of two and ≥ IPL = BURST_BEATS*IPB.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- entry  in  64  initial PC, sampled while reset is low.
- redirect_valid  in  1  one-cycle restart request.
- redirect_pc  in  64  restart PC; low log2(INSTR_WIDTH/8) bits ignored.
- bus_reqcyc  out  1  request valid.
- bus_req  out  BUS_DATA_WIDTH  line-aligned fetch address.
- bus_reqtag  out  BUS_TAG_WIDTH  {1'b1, SYSBUS_MEMORY, 8'b0}.
- bus_reqack  in  1  request accepted.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  response beat.
- bus_resptag  in  BUS_TAG_WIDTH  unused; a single request is outstanding at any time.
- bus_respack  out  1  beat consumed this cycle.
- instr_valid  out  1  FIFO head valid.
- instr  out  INSTR_WIDTH  head instruction.
- instr_pc  out  64  head instruction address.
- instr_ready  in  1  consumer pops head when high with instr_valid.

## Operation
- States: WAIT_SPACE, REQ, RESP, DRAIN. Reset value is REQ. On reset, fetch_pc = entry, FIFO is empty, and the beat counter is 0.
- WAIT_SPACE: move to REQ when FIFO free entries ≥ IPL. This guarantees room for a whole line, so beats are never backpressured.
- REQ: bus_reqcyc=1, bus_req = fetch_pc & ~(LINE_BYTES-1). Hold the request until bus_reqack. On ack, go to RESP with the beat counter at 0.
- RESP: bus_respack = bus_respcyc. Each accepted beat at index b carries IPB instructions. Lane k occupies bits [k*INSTR_WIDTH +: INSTR_WIDTH], with lane 0 oldest.
  - Address of lane k = line_base + b*BUS_DATA_WIDTH/8 + k*INSTR_WIDTH/8.
  - Write lanes with address ≥ fetch_pc into the FIFO, in order. Lanes below fetch_pc (unaligned entry or redirect) are dropped.
  - After the last beat: fetch_pc = line_base + LINE_BYTES, then go to WAIT_SPACE.
- DRAIN: same handshake as RESP, but all beats are discarded. After the last beat, go to WAIT_SPACE.
- Redirect (highest priority):
  - On the clock edge: flush the FIFO and set fetch_pc = redirect_pc.
  - From REQ: the request must still complete. Go to DRAIN after ack, or directly to DRAIN if the ack arrives in the same cycle.
  - From RESP with beats remaining: go to DRAIN. If it coincides with the final beat, discard the beat and go to WAIT_SPACE.
  - From WAIT_SPACE: stay in WAIT_SPACE.
- A pop in the same cycle as a redirect is lost (the flush wins). A pop and a push in the same cycle are both performed.
- Arithmetic: PCs are 64-bit and wrap modulo 2^64. The beat counter is $clog2(BURST_BEATS)+1 bits.

## Timing
- While reset is low, every output is 0.
- bus_reqcyc rises in the first cycle after reset goes high.
- bus_respack is combinational from bus_respcyc, in RESP/DRAIN only.
- A beat accepted at edge N is visible as instr_valid=1 in cycle N+1 (registered write, show-ahead read).
- After a redirect at edge N, instr_valid=0 in cycle N+1. The first new instruction appears at the earliest one cycle after its beat is accepted.
- If reset is asserted mid-burst, the FIFO and FSM are abandoned. The bus is assumed to be reset together with the block.

## Structure
- fetch_pkg holds:
  - the state enum;
  - localparams IPB, IPL, LINE_BYTES;
  - the FETCH_TAG constant built from SYSBUS_MEMORY, via Sysbus.defs.
- Sub-module fetch_fifo: a synchronous FIFO with width INSTR_WIDTH+64 and depth FIFO_DEPTH. It supports up to IPB writes per cycle, one pop per cycle, a flush, and a free-count output.

## Test plan
- Aligned entry 0x1000: ack after 3 cycles, 8 beats with instr_ready held high. Expect bus_req=0x1000 and 16 instructions with PCs 0x1000..0x103C in order; the next request is 0x1040.
- Unaligned entry 0x1014: expect bus_req=0x1000, beats 0–1 and lane 0 of beat 2 dropped, first instr_pc=0x1014, 11 instructions total.
- instr_ready held low: expect the second line to be fetched (FIFO holds 32 entries) and no third request until 16 entries have been popped.
- Redirect to 0x2008 after beat 3 of a burst: expect instr_valid=0 on the next cycle, remaining beats acked and discarded, then bus_req=0x2000 and first instr_pc=0x2008.
- Redirect during REQ with reqack delayed by 5 cycles: expect bus_reqcyc held, all 8 beats drained, then a request to the new line.
- Redirect in the same cycle as the final beat and a pop: expect the FIFO empty, the beat discarded, and the new request issued.
